// File: rtl/contador_regressivo_3bits.sv
// -----------------------------------------------------------------------------
// contador_regressivo_3bits
//
// Loadable 3-bit countdown timer with start/pause control and an active-low
// 7-segment digit. The counter runs on the board clock and decrements only on
// single-cycle tick enables coming from the frequency divider.
//
// Ports
//   clock        in   system clock, all state changes on the rising edge
//   reset        in   asynchronous, active-high reset
//   tick         in   count enable pulse from the divider
//   start        in   start/pause request, acted on at its rising edge
//   load         in   synchronous load request, sampled on every edge
//   load_value   in   [2:0] value captured while load is high
//   q            out  [2:0] current count
//   running      out  high while the FSM is in RUN
//   done         out  high while the FSM is in DONE
//   HEX0         out  [0:6] active-low segments, HEX0[0]=a ... HEX0[6]=g
//   state_dbg_o  out  [1:0] raw FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//
// Edge priority: load > start rising edge > tick.
// -----------------------------------------------------------------------------
module contador_regressivo_3bits (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       load,
    input  logic [2:0] load_value,
    output logic [2:0] q,
    output logic       running,
    output logic       done,
    output logic [0:6] HEX0,
    output logic [1:0] state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [2:0] start_val_q, start_val_d;
    logic       start_prev_q;

    // One event per press: holding start high does not retrigger.
    logic sedge;
    assign sedge = start & ~start_prev_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 3'd0;
            start_val_q  <= 3'd0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            start_val_q  <= start_val_d;
            start_prev_q <= start;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        start_val_d = start_val_q;

        if (load) begin
            // Load overrides everything, including a coincident start edge.
            count_d     = load_value;
            start_val_d = load_value;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sedge) begin
                        state_d = (count_q != 3'd0) ? RUN : DONE;
                    end
                end

                RUN: begin
                    if (sedge) begin
                        // Pause takes the edge; a coincident tick is dropped.
                        state_d = PAUSE;
                    end else if (tick && (count_q != 3'd0)) begin
                        count_d = count_q - 3'd1;
                        // Terminal count: reach zero and flag DONE together.
                        if (count_q == 3'd1) begin
                            state_d = DONE;
                        end
                    end
                end

                PAUSE: begin
                    if (sedge) begin
                        state_d = RUN;
                    end
                end

                DONE: begin
                    if (sedge) begin
                        // Restart from the last loaded value.
                        count_d = start_val_q;
                        state_d = (start_val_q != 3'd0) ? RUN : DONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q           = count_q;
    assign running     = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign state_dbg_o = state_q;

    // Active-low segment decode; literal MSB lands on HEX0[0] (segment a).
    always_comb begin
        HEX0 = 7'b1111111;
        case (count_q)
            3'd0:    HEX0 = 7'b0000001;
            3'd1:    HEX0 = 7'b1001111;
            3'd2:    HEX0 = 7'b0010010;
            3'd3:    HEX0 = 7'b0000110;
            3'd4:    HEX0 = 7'b1001100;
            3'd5:    HEX0 = 7'b0100100;
            3'd6:    HEX0 = 7'b0100000;
            3'd7:    HEX0 = 7'b0001111;
            default: HEX0 = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_contador_regressivo_3bits.sv
// -----------------------------------------------------------------------------
// tb_contador_regressivo_3bits
//
// Directed bench for the 3-bit countdown timer. Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_contador_regressivo_3bits;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       start;
    logic       load;
    logic [2:0] load_value;
    logic [2:0] q;
    logic       running;
    logic       done;
    logic [0:6] HEX0;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    contador_regressivo_3bits dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .load        (load),
        .load_value  (load_value),
        .q           (q),
        .running     (running),
        .done        (done),
        .HEX0        (HEX0),
        .state_dbg_o (state_dbg)
    );

    // -------------------------------------------------------------------------
    // Clock and watchdog
    // -------------------------------------------------------------------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Driver and check tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] eq, input logic [6:0] ehex,
                             input logic erun, input logic edone);
        check({tag, "_q"},       {5'd0, q},       {5'd0, eq});
        check({tag, "_hex"},     {1'b0, HEX0},    {1'b0, ehex});
        check({tag, "_running"}, {7'd0, running}, {7'd0, erun});
        check({tag, "_done"},    {7'd0, done},    {7'd0, edone});
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        reset      = 1'b1;
        tick       = 1'b0;
        start      = 1'b0;
        load       = 1'b0;
        load_value = 3'd0;
        #1;
        check_all("por", 3'd0, 7'b0000001, 1'b0, 1'b0);
        check("por_state", {6'd0, state_dbg}, 8'd0);
        #2 reset = 1'b0;

        // ---- countdown from 3 with a tick every 4 cycles ----
        step();
        load_value = 3'd3; load = 1'b1;
        step();
        load = 1'b0;
        check_all("load3", 3'd3, 7'b0000110, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("start3", 3'd3, 7'b0000110, 1'b1, 1'b0);
        step(); step(); step();
        tick = 1'b1; step(); tick = 1'b0;
        check_all("cd_2", 3'd2, 7'b0010010, 1'b1, 1'b0);
        step(); step(); step();
        tick = 1'b1; step(); tick = 1'b0;
        check_all("cd_1", 3'd1, 7'b1001111, 1'b1, 1'b0);
        step(); step(); step();
        tick = 1'b1; step(); tick = 1'b0;
        check_all("cd_0", 3'd0, 7'b0000001, 1'b0, 1'b1);
        tick = 1'b1; step(); step(); tick = 1'b0;
        check_all("hold0", 3'd0, 7'b0000001, 1'b0, 1'b1);

        // ---- restart from DONE ----
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("restart", 3'd3, 7'b0000110, 1'b1, 1'b0);

        // ---- pause and resume ----
        load_value = 3'd7; load = 1'b1;
        step();
        load = 1'b0;
        check_all("load7", 3'd7, 7'b0001111, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); step(); tick = 1'b0;
        check_all("two_ticks", 3'd5, 7'b0100100, 1'b1, 1'b0);
        start = 1'b1; tick = 1'b1;
        step();
        start = 1'b0;
        check_all("pause_edge", 3'd5, 7'b0100100, 1'b0, 1'b0);
        check("pause_state", {6'd0, state_dbg}, 8'd2);
        step(); step(); step();
        tick = 1'b0;
        check_all("paused_ticks", 3'd5, 7'b0100100, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check_all("resume", 3'd5, 7'b0100100, 1'b1, 1'b0);
        tick = 1'b1; step(); tick = 1'b0;
        check_all("resume_tick", 3'd4, 7'b1001100, 1'b1, 1'b0);

        // ---- priority: load + tick + start edge on one edge ----
        load = 1'b1; load_value = 3'd6; tick = 1'b1; start = 1'b1;
        step();
        load = 1'b0; tick = 1'b0; start = 1'b0;
        check_all("priority", 3'd6, 7'b0100000, 1'b0, 1'b0);
        check("priority_state", {6'd0, state_dbg}, 8'd0);

        // ---- zero load ----
        load = 1'b1; load_value = 3'd0;
        step();
        load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check_all("zero_start", 3'd0, 7'b0000001, 1'b0, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        check_all("zero_restart", 3'd0, 7'b0000001, 1'b0, 1'b1);

        // ---- start held high gives a single event ----
        load = 1'b1; load_value = 3'd2;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        check_all("held_1", 3'd2, 7'b0010010, 1'b1, 1'b0);
        step(); step();
        check_all("held_3", 3'd2, 7'b0010010, 1'b1, 1'b0);
        start = 1'b0;

        // ---- reset mid-RUN with q=5, asynchronous ----
        load = 1'b1; load_value = 3'd5;
        step();
        load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check_all("pre_reset", 3'd5, 7'b0100100, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_all("async_reset", 3'd0, 7'b0000001, 1'b0, 1'b0);
        // start held high through release counts as an edge; q=0 -> DONE
        start = 1'b1;
        step();
        #2 reset = 1'b0;
        step();
        start = 1'b0;
        check_all("post_reset", 3'd0, 7'b0000001, 1'b0, 1'b1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_regressivo_3bits.md
# contador_regressivo_3bits

Loadable 3-bit countdown timer with start/pause control and an active-low 7-segment output. It runs off the board clock and decrements only on single-cycle `tick` enables from the frequency divider. It complements the up-counting display path: the counter runs from a loaded value down to zero, flags completion, and drives a HEX digit directly.

## Interface
- No parameters; the width is fixed at 3 bits.
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high. Forces every register to its reset value.
- `tick` input 1: count enable, a one-`clock` pulse from the divider.
- `start` input 1: start/pause request. The block acts on its rising edge.
- `load` input 1: synchronous load request. It is level-sampled on every edge.
- `load_value` input 3: value captured when `load`=1.
- `q` output 3: current count.
- `running` output 1: high while in RUN.
- `done` output 1: high while in DONE.
- `HEX0[0:6]` output 7: active-low segments. `HEX0[0]`=a … `HEX0[6]`=g.

## Operation
- Internal registers:
  - `state`: one of IDLE, RUN, PAUSE, DONE.
  - `q`.
  - `start_val`: the last loaded value.
  - `start_d`: the `start` sample from the previous edge.
- Start edge: `sedge` = `start` & ~`start_d`. `start_d` is updated every edge.
- Priority on every edge: `load` > `sedge` > `tick`.
- Any state with `load`=1:
  - `q` ← `load_value`.
  - `start_val` ← `load_value`.
  - `state` ← IDLE.
- IDLE:
  - On `sedge`: go to RUN if `q`≠0. Otherwise go to DONE.
  - `tick` is ignored.
- RUN:
  - On `sedge`: go to PAUSE, and do not decrement even if `tick`=1.
  - On `tick`: `q` ← `q`−1. If `q`=1 at that edge, `q` becomes 0 and `state` ← DONE on the same edge.
- PAUSE:
  - `q` holds and `tick` is ignored.
  - On `sedge`: go to RUN.
- DONE:
  - `q` holds at 0.
  - On `sedge`: `q` ← `start_val`. Then go to RUN if `start_val`≠0, otherwise stay in DONE.
- `q` never wraps. The decrement from 0 is unreachable, because RUN is never entered with `q`=0.
- `running` = (`state`==RUN). `done` = (`state`==DONE). Both are decoded from registered state.
- `HEX0` is decoded combinationally from `q`. Values are `HEX0[0:6]`, active-low:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111

## Timing
- Reset values, effective immediately and independent of `clock`:
  - `state` = IDLE.
  - `q` = 000.
  - `start_val` = 000.
  - `start_d` = 0.
  - `running` = 0.
  - `done` = 0.
  - `HEX0` = 0000001.
- Reset asserted mid-count aborts at once. The first edge after release is evaluated normally. A `start` held high through reset release counts as a rising edge on that first edge.
- `load`: `q` and `HEX0` show the new value after the same edge at which `load`=1.
- `sedge` → state change: the edge where `start`=1 and `start_d`=0, so `running` rises one edge after `start` rises. Holding `start` high produces a single event.
- `tick` → `q` update: the same edge. `HEX0` follows `q` within that cycle with no extra latency.
- Terminal count: `done` rises on the edge that moves `q` from 1 to 0. `running` falls on that same edge.
- `tick` held high for multiple cycles decrements once per edge. This is legal, and the block does not check pulse width.
- Simultaneous events:
  - `load`+`sedge`: load wins, and `state` is IDLE afterwards.
  - `sedge`+`tick` in RUN: pause, no decrement.
  - `load`+`tick`: load wins.

## Test plan
- Reset check: assert `reset` mid-RUN with `q`=5 → `q`=000, `HEX0`=0000001, `running`=0 and `done`=0 with no clock edge.
- Countdown to done:
  - Stimulus: `load_value`=3 with `load` pulse, `start` pulse, then a `tick` every 4 cycles.
  - Required: `q` goes 3→2→1→0; `HEX0` goes 0000110, 0010010, 1001111, 0000001.
  - Required: `done`=1 on the 1→0 edge, then `q` holds at 0 under further ticks.
- Pause and resume:
  - Stimulus: load 7, start, two ticks (`q`=5), `start` edge concurrent with a `tick`, 3 more ticks, then a `start` edge and one tick.
  - Required: `q` stays at 5 through the concurrent edge and the 3 ticks; after resume the tick gives `q`=4.
- Restart from DONE: after scenario 2, a `start` edge → `q`=3 and `running`=1 on the next edge.
- Zero load: load 0 then start → DONE immediately, `q`=0 and `running` never asserts. A `start` from DONE stays in DONE.
- Priority: in RUN with `q`=4, `load`=1, `load_value`=6, `tick`=1 and a `start` edge all on one edge → `q`=6, IDLE, `running`=0.
